// File: rtl/multu_sequencer.sv
// rtl/multu_sequencer.sv - unsigned shift-add multiply sequencer owning the HI/LO result registers
//
// Purpose: accepts MULTU / MFHI / MFLO / OUT function codes, runs a WIDTH-step
// shift-add multiply under a two-state FSM (IDLE, RUN) and serves HI/LO reads.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   op_valid   in   Signal/dataA/dataB carry an operation this cycle
//   op_ready   out  operation accepted this cycle (high exactly in IDLE)
//   Signal     in   6-bit function code
//   dataA      in   multiplicand (MULTU only)
//   dataB      in   multiplier (MULTU only)
//   busy       out  iteration in progress (RUN)
//   done       out  one-cycle pulse: HI/LO were written on the preceding edge
//   dataOut    out  registered read result
//   out_valid  out  one-cycle pulse: dataOut holds a fresh read result
module multu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [5:0]           Signal,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 out_valid
);

    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_OUT   = 6'b111111;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;

    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   data_out_q, data_out_d;
    logic                 done_q, done_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic                 last_step;
    logic [2*WIDTH-1:0]   step_sum;

    // Product after this edge's conditional add; on the last step this is
    // the full result that lands in HI/LO.
    assign step_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (state_q == ST_RUN) && (cnt_q == LAST_STEP);
    assign accept    = op_valid && op_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (Signal == FN_MULTU)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        op_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: op_ready = 1'b1;
            ST_RUN:  busy     = 1'b1;
            default: op_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        data_out_d  = data_out_q;
        done_d      = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (Signal)
                        FN_MULTU: begin
                            mcand_d  = {{WIDTH{1'b0}}, dataA};
                            mplier_d = dataB;
                            prod_d   = '0;
                            cnt_d    = '0;
                        end
                        FN_MFHI: begin
                            data_out_d  = {{WIDTH{1'b0}}, hi_q};
                            out_valid_d = 1'b1;
                        end
                        FN_MFLO: begin
                            data_out_d  = {{WIDTH{1'b0}}, lo_q};
                            out_valid_d = 1'b1;
                        end
                        FN_OUT: begin
                            data_out_d  = {hi_q, lo_q};
                            out_valid_d = 1'b1;
                        end
                        // Unrecognised codes are consumed without effect.
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                prod_d   = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_step) begin
                    hi_d   = step_sum[2*WIDTH-1:WIDTH];
                    lo_d   = step_sum[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            data_out_q  <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            data_out_q  <= data_out_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign dataOut   = data_out_q;

endmodule

// File: tb/tb_multu_sequencer.sv
// tb/tb_multu_sequencer.sv - self-checking bench for multu_sequencer
module tb_multu_sequencer;

    localparam logic [5:0] C_MULTU = 6'b011001;
    localparam logic [5:0] C_MFHI  = 6'b010000;
    localparam logic [5:0] C_MFLO  = 6'b010010;
    localparam logic [5:0] C_OUT   = 6'b111111;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [63:0] dataOut;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    // Reference state: what HI/LO must hold according to the arithmetic.
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    multu_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .Signal    (Signal),
        .dataA     (dataA),
        .dataB     (dataB),
        .busy      (busy),
        .done      (done),
        .dataOut   (dataOut),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_read(input logic [5:0] sig);
        case (sig)
            C_MFHI:  return {32'b0, hi_m};
            C_MFLO:  return {32'b0, lo_m};
            default: return {hi_m, lo_m};
        endcase
    endfunction

    function automatic void model_mult(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        hi_m = p[63:32];
        lo_m = p[31:0];
    endfunction

    // Called at a negedge; presents an operation for one edge and returns
    // at the negedge after the acceptance edge.
    task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        Signal   = sig;
        dataA    = a;
        dataB    = b;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        Signal   = 6'b0;
        dataA    = '0;
        dataB    = '0;
    endtask

    // Starts a multiply and returns on the done cycle (or after a bound).
    // cyc counts cycles from acceptance to the cycle where done is seen.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            output int cyc, output logic busy_seen);
        issue(C_MULTU, a, b);
        busy_seen = busy;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        model_mult(a, b);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        op_valid = 1'b0;
        Signal   = 6'b0;
        dataA    = '0;
        dataB    = '0;
        hi_m     = '0;
        lo_m     = '0;
        repeat (2) @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b expected 1", op_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (dataOut !== 64'h0) begin errors++; $display("FAIL reset_dataOut: got %h expected 0", dataOut); end
        reset = 1'b1;
        issue(C_OUT, '0, '0);
        checks++; if (dataOut !== 64'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL reset_hilo: got %h/%b expected 0/1", dataOut, out_valid); end
    endtask

    task automatic test_basic();
        int cyc; logic bs;
        run_mult(32'd3, 32'd5, cyc, bs);
        checks++; if (bs !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bs); end
        checks++; if (cyc !== 33) begin errors++; $display("FAIL basic_latency: got %0d expected 33", cyc); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_on_done: got %b expected 1", op_ready); end
        issue(C_OUT, '0, '0);
        checks++; if (dataOut !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL basic_out: got %h expected 000000000000000f", dataOut); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_pulse: got %b expected 0", out_valid); end
    endtask

    task automatic test_max();
        int cyc; logic bs;
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bs);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL max_latency: got %0d expected 33", cyc); end
        issue(C_MFHI, '0, '0);
        checks++; if (dataOut !== 64'h0000_0000_FFFF_FFFE || out_valid !== 1'b1) begin errors++; $display("FAIL max_mfhi: got %h/%b expected 00000000fffffffe/1", dataOut, out_valid); end
        issue(C_MFLO, '0, '0);
        checks++; if (dataOut !== 64'h0000_0000_0000_0001 || out_valid !== 1'b1) begin errors++; $display("FAIL max_mflo: got %h/%b expected 0000000000000001/1", dataOut, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_out_valid_pulse: got %b expected 0", out_valid); end
    endtask

    task automatic test_zero_bit31();
        int cyc; logic bs;
        run_mult(32'h0, 32'hDEAD_BEEF, cyc, bs);
        issue(C_OUT, '0, '0);
        checks++; if (dataOut !== 64'h0) begin errors++; $display("FAIL zero_operand: got %h expected 0", dataOut); end
        run_mult(32'h8000_0000, 32'd2, cyc, bs);
        issue(C_OUT, '0, '0);
        checks++; if (dataOut !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL bit31_operand: got %h expected 0000000100000000", dataOut); end
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        issue(C_MULTU, a, b);
        model_mult(a, b);
        op_valid = 1'b1;
        Signal   = C_MFLO;
        n = 0;
        while (op_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL stall_cycles: got %0d expected 32", n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", done); end
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        Signal   = 6'b0;
        checks++; if (out_valid !== 1'b1 || dataOut !== model_read(C_MFLO)) begin errors++; $display("FAIL stall_read: got %h/%b expected %h/1", dataOut, out_valid, model_read(C_MFLO)); end
    endtask

    task automatic test_reset_mid();
        int cyc; logic bs;
        issue(C_MULTU, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
        #1;
        checks++; if (busy !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL midreset_busy: got busy=%b ready=%b expected 0/1", busy, op_ready); end
        @(negedge clk);
        reset = 1'b1;
        issue(C_OUT, '0, '0);
        checks++; if (dataOut !== 64'h0) begin errors++; $display("FAIL midreset_hilo: got %h expected 0", dataOut); end
        run_mult(32'd7, 32'd9, cyc, bs);
        issue(C_MFLO, '0, '0);
        checks++; if (dataOut !== 64'd63) begin errors++; $display("FAIL midreset_rerun: got %h expected 3f", dataOut); end
    endtask

    task automatic test_back_to_back();
        int cyc; logic bs;
        logic [63:0] held;
        run_mult(32'd4, 32'd4, cyc, bs);
        issue(C_OUT, '0, '0);
        checks++; if (dataOut !== 64'd16) begin errors++; $display("FAIL b2b_first: got %h expected 10", dataOut); end
        run_mult(32'd4, 32'd4, cyc, bs);
        // Second multiply presented on the done cycle of the first.
        run_mult(32'd2, 32'd3, cyc, bs);
        checks++; if (bs !== 1'b1 || cyc !== 33) begin errors++; $display("FAIL b2b_accept: got busy=%b cyc=%0d expected 1/33", bs, cyc); end
        issue(C_OUT, '0, '0);
        checks++; if (dataOut !== 64'd6) begin errors++; $display("FAIL b2b_second: got %h expected 6", dataOut); end
        held = dataOut;
        issue(6'b000000, 32'h1234_5678, 32'h9ABC_DEF0);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || dataOut !== held) begin errors++; $display("FAIL unknown_code: got ov=%b busy=%b d=%h expected 0/0/%h", out_valid, busy, dataOut, held); end
        issue(C_OUT, '0, '0);
        checks++; if (dataOut !== 64'd6) begin errors++; $display("FAIL unknown_hilo: got %h expected 6", dataOut); end
    endtask

    task automatic test_random();
        int cyc; logic bs;
        logic [31:0] a, b;
        logic [5:0] sig;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) a = '0;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
            run_mult(a, b, cyc, bs);
            checks++; if (cyc !== 33) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 33", i, cyc); end
            for (int r = 0; r < 3; r++) begin
                case ($urandom_range(0, 3))
                    0: sig = C_MFHI;
                    1: sig = C_MFLO;
                    2: sig = C_OUT;
                    default: sig = 6'b000101;
                endcase
                if (sig == 6'b000101) begin
                    issue(sig, $urandom, $urandom);
                    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_unknown[%0d]: got ov=%b expected 0", i, out_valid); end
                end else begin
                    issue(sig, '0, '0);
                    checks++; if (out_valid !== 1'b1 || dataOut !== model_read(sig)) begin errors++; $display("FAIL rand_read[%0d] sig=%b a=%h b=%h: got %h/%b expected %h/1", i, sig, a, b, dataOut, out_valid, model_read(sig)); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero_bit31();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multu_sequencer.md
# multu_sequencer

Sequencer for the unsigned shift-add multiply unit: accepts MULTU, MFHI, MFLO and OUT function codes from the ALU control, runs the 32-step shift-add iteration under FSM control, and owns the HI/LO result registers. It sits beside the ALU in the execute stage. It stalls issue (`op_ready` low) while an iteration is in flight, so HI/LO reads never return a partial product.

## Interface
- `WIDTH`, 32: operand width; HI/LO are `WIDTH` each, product `2*WIDTH`.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  `Signal`/`dataA`/`dataB` carry an operation this cycle.
- `op_ready`  out  1  block accepts an operation this cycle; high exactly when FSM is IDLE.
- `Signal`  in  6  function code: MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010, OUT=6'b111111.
- `dataA`, `dataB`  in  32 each  multiplicand and multiplier (MULTU only).
- `busy`  out  1  iteration in progress (FSM in RUN).
- `done`  out  1  one-cycle pulse: HI/LO were updated on the preceding edge.
- `dataOut`  out  64  read result.
- `out_valid`  out  1  one-cycle pulse: `dataOut` holds a fresh read result.

## Operation
- Handshake: an operation is accepted on a rising edge where `op_valid && op_ready`. Inputs are sampled only at acceptance.
- FSM states:
  - IDLE: `op_ready`=1.
  - RUN: `op_ready`=0, `busy`=1.
- IDLE + accepted MULTU: load `mcand`={32'b0,dataA}, `mplier`=dataB, `prod`=0, `cnt`=0, and go to RUN.
- RUN step, each edge:
  - if `mplier[0]`, `prod`<=`prod`+`mcand` (64-bit, modulo 2^64; it never overflows for 32x32).
  - `mcand`<<=1, `mplier`>>=1 (logical), `cnt`++.
- Final step: on the step with `cnt`==31, HI<=sum[63:32] and LO<=sum[31:0], where sum is the final `prod` including that step's add. Go to IDLE and pulse `done` for the next cycle.
- Reads (accepted only in IDLE):
  - MFHI: `dataOut`<={32'b0,HI}.
  - MFLO: `dataOut`<={32'b0,LO}.
  - OUT: `dataOut`<={HI,LO}.
  - Each read pulses `out_valid` for one cycle. HI/LO are unchanged.
- Any other code with `op_valid` in IDLE: accepted and ignored. No state change, no pulse.
- `dataOut` holds its last value until the next read.
- A MULTU accepted immediately after `done` starts a new iteration. HI/LO keep the old result until that new iteration completes.
- `op_valid` in RUN: not accepted. The requester must hold the operation until `op_ready`.

## Timing
- Reset (`reset`=0, asynchronous) forces:
  - FSM=IDLE;
  - HI, LO, `prod`, `mcand`, `mplier`, `cnt`, `dataOut` = 0;
  - `busy`, `done`, `out_valid` = 0;
  - `op_ready`=1 (combinational from state).
- Reset asserted mid-RUN aborts the iteration; HI/LO read 0 afterwards.
- Reset release is synchronised by the requester. The first acceptance can occur on the first rising edge with `reset`=1.
- MULTU latency, with the acceptance edge as E0:
  - RUN steps occur on edges E1..E32.
  - HI/LO are valid after E32. `done`=1 and `op_ready`=1 in the cycle following E32.
  - `busy`=1 from after E0 through E32.
- Throughput: one MULTU per 33 cycles.
- Read latency: `dataOut`/`out_valid` are registered and valid the cycle after the acceptance edge. Back-to-back reads are allowed every cycle.
- `busy`, `done` and `out_valid` are never high on an accepted-read cycle simultaneously with RUN.

## Test plan
- Basic multiply: reset, MULTU A=3, B=5, wait for `done` -> exactly 33 cycles after acceptance. Then OUT -> `dataOut`=64'h0000_0000_0000_000F.
- Maximum operands: MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF, then MFHI then MFLO -> HI=32'hFFFFFFFE, LO=32'h00000001, each read with a 1-cycle `out_valid`.
- Zero and bit-31 operands: MULTU A=0, B=32'hDEADBEEF -> {HI,LO}=0. MULTU A=32'h80000000, B=2 -> HI=1, LO=0.
- Stall during RUN: hold `op_valid` with MFLO from E1 -> `op_ready`=0 for 32 cycles, the MFLO is accepted on the `done` cycle, and it returns the new LO.
- Reset mid-operation: MULTU 7x9, assert `reset` at E10 -> `busy`=0 immediately, HI=LO=0. A fresh MULTU 7x9 afterwards -> LO=63.
- Back-to-back and unknown codes: MULTU 2x3 accepted on the `done` cycle of a prior 4x4 -> HI/LO read 16 until the second `done`, then 6. `Signal`=6'b000000 with `op_valid` in IDLE -> no `out_valid`, HI/LO unchanged.
